// File: rtl/lsu_pkg.sv
// Shared encodings and address helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } lsu_state_t;

  // Word-aligned address seen by the data memory.
  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) mis = offset[0];
    else if (size == SZ_WORD) mis = (offset != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extraction (with sign/zero extension) and lane merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed byte/half and extend it for loads.
  always_comb begin
    byte_lane = mem_word[31:24];
    case (offset)
      2'd0: byte_lane = mem_word[31:24];
      2'd1: byte_lane = mem_word[23:16];
      2'd2: byte_lane = mem_word[15:8];
      2'd3: byte_lane = mem_word[7:0];
      default: byte_lane = mem_word[31:24];
    endcase
    half_lane = offset[1] ? mem_word[15:0] : mem_word[31:16];
    load_data = mem_word;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: load_data = mem_word;
    endcase
  end

  // Drop the low byte/half of the store data into the addressed lane.
  always_comb begin
    merged_word = mem_word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0: merged_word[31:24] = store_data[7:0];
          2'd1: merged_word[23:16] = store_data[7:0];
          2'd2: merged_word[15:8]  = store_data[7:0];
          2'd3: merged_word[7:0]   = store_data[7:0];
          default: merged_word = mem_word;
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged_word[15:0] = store_data[15:0];
        else merged_word[31:16] = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit in front of a word-wide big-endian data memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic        We,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic        AddrErr,
  output logic [31:0] RData,
  output logic [31:0] DmAddr,
  output logic [31:0] DmDataIn,
  output logic        DmRD,
  output logic        DmWR,
  input  logic [31:0] DmDataOut
);

  lsu_state_t state, next_state;

  logic        req_we;
  logic        req_unsigned;
  logic        req_err;
  logic [1:0]  req_size;
  logic [1:0]  req_off;
  logic [31:0] req_wdata;

  logic        accept_err;
  logic [1:0]  eff_off;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  // Classify the incoming request and force the offset to the access alignment.
  always_comb begin
    accept_err = (Size == SZ_ILL) || (CHECK_ALIGN && is_misaligned(Size, Addr[1:0]));
    eff_off = Addr[1:0];
    if (Size == SZ_HALF) eff_off = {Addr[1], 1'b0};
    else if (Size == SZ_WORD) eff_off = 2'b00;
  end

  lsu_lane_align u_lane (
    .size        (req_size),
    .offset      (req_off),
    .is_unsigned (req_unsigned),
    .mem_word    (DmDataOut),
    .store_data  (req_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // State register; reset drops straight back to IDLE, killing any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  end

  // Next-state and strobe decode; strobes come only from state so reset clears them at once.
  always_comb begin
    next_state = state;
    Busy       = (state != IDLE);
    Done       = 1'b0;
    AddrErr    = 1'b0;
    DmRD       = 1'b0;
    DmWR       = 1'b0;
    case (state)
      IDLE: begin
        if (Req) begin
          if (accept_err) next_state = DONE;
          else if (We && (Size == SZ_WORD)) next_state = WRITE;
          else next_state = READ;
        end
      end
      READ: begin
        DmRD       = 1'b1;
        next_state = req_we ? WRITE : DONE;
      end
      WRITE: begin
        DmWR       = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        AddrErr    = req_err;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, memory address/data registers and the load result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we       <= 1'b0;
      req_unsigned <= 1'b0;
      req_err      <= 1'b0;
      req_size     <= SZ_BYTE;
      req_off      <= 2'b00;
      req_wdata    <= '0;
      RData        <= '0;
      DmAddr       <= '0;
      DmDataIn     <= '0;
    end else if ((state == IDLE) && Req) begin
      req_we       <= We;
      req_unsigned <= Unsigned;
      req_err      <= accept_err;
      req_size     <= Size;
      req_off      <= eff_off;
      req_wdata    <= WData;
      DmAddr       <= align_addr(Addr);
      if (We && (Size == SZ_WORD) && !accept_err) DmDataIn <= WData;
    end else if (state == READ) begin
      if (req_we) DmDataIn <= merged_word;
      else RData <= load_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a falling-edge word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Req = 1'b0;
  logic        We = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        Unsigned = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WData = '0;
  logic        Busy, Done, AddrErr, DmRD, DmWR;
  logic [31:0] RData, DmAddr, DmDataIn;
  wire  [31:0] DmDataOut;

  logic [31:0] mem [0:63];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Req       (Req),
    .We        (We),
    .Size      (Size),
    .Unsigned  (Unsigned),
    .Addr      (Addr),
    .WData     (WData),
    .Busy      (Busy),
    .Done      (Done),
    .AddrErr   (AddrErr),
    .RData     (RData),
    .DmAddr    (DmAddr),
    .DmDataIn  (DmDataIn),
    .DmRD      (DmRD),
    .DmWR      (DmWR),
    .DmDataOut (DmDataOut)
  );

  always #5 clk = ~clk;

  assign DmDataOut = DmRD ? mem[DmAddr[7:2]] : 32'bz;

  // Data memory model: preload, then write on each falling edge with DmWR high.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h8877_6655;
    mem[12] = 32'h1111_1111;
    forever begin
      @(negedge clk);
      if (DmWR) mem[DmAddr[7:2]] = DmDataIn;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input bit poke);
    int          lat = -1;
    int          rd = 0;
    int          wr = 0;
    int          both = 0;
    int          stray = 0;
    logic [31:0] seen_wdata = '0;
    exp_t        e;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (DmRD) rd++;
      if (DmWR) begin
        wr++;
        seen_wdata = DmDataIn;
      end
      if (DmRD && DmWR) both++;
      if (AddrErr && !Done) stray++;
      if (Done) begin
        lat = c;
        break;
      end
    end
    e = sb.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(e.lat));
    check({tag, " AddrErr"}, {31'd0, AddrErr}, {31'd0, e.err});
    check({tag, " RData"}, RData, e.rdata);
    check({tag, " DmRD cycles"}, 32'(rd), 32'(e.rd));
    check({tag, " DmWR cycles"}, 32'(wr), 32'(e.wr));
    check({tag, " RD/WR overlap"}, 32'(both), 32'd0);
    check({tag, " stray AddrErr"}, 32'(stray), 32'd0);
    if (e.wr > 0) check({tag, " DmDataIn"}, seen_wdata, e.wdata);
    if (poke) begin
      @(posedge clk);
      #1 Req = 1'b0;
      @(negedge clk);
      check({tag, " Busy after ignored Req"}, {31'd0, Busy}, 32'd0);
      check({tag, " Done after ignored Req"}, {31'd0, Done}, 32'd0);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                                input int exp_rd, input int exp_wr, input logic [31:0] exp_wdata,
                                input bit poke);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    e.rd    = exp_rd;
    e.wr    = exp_wr;
    e.wdata = exp_wdata;
    sb.push_back(e);
    @(posedge clk);
    #1;
    Req = 1'b1; We = we; Size = size; Unsigned = uns; Addr = addr; WData = wdata;
    @(posedge clk);
    #1;
    Addr = $urandom;
    WData = $urandom;
    Unsigned = ~uns;
    Size = 2'($urandom_range(0, 3));
    if (poke) begin
      Req = 1'b1; We = 1'b1; Size = SZ_WORD; Addr = 32'h20; WData = 32'h5555_5555;
    end else begin
      Req = 1'b0;
    end
    check_output(tag, poke);
  endtask

  initial begin
    #12;
    check("reset Busy", {31'd0, Busy}, 32'd0);
    check("reset Done", {31'd0, Done}, 32'd0);
    check("reset AddrErr", {31'd0, AddrErr}, 32'd0);
    check("reset DmRD", {31'd0, DmRD}, 32'd0);
    check("reset DmWR", {31'd0, DmWR}, 32'd0);
    check("reset RData", RData, 32'd0);
    check("reset DmAddr", DmAddr, 32'd0);
    check("reset DmDataIn", DmDataIn, 32'd0);
    rst_n = 1'b1;

    apply_stimulus("LB 0x10",  1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 32'hFFFF_FF88, 1'b0, 2, 1, 0, 32'h0, 1'b0);
    apply_stimulus("LBU 0x13", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'h0000_0055, 1'b0, 2, 1, 0, 32'h0, 1'b0);
    apply_stimulus("LH 0x12",  1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h0000_6655, 1'b0, 2, 1, 0, 32'h0, 1'b0);
    apply_stimulus("LHU 0x10", 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'h0000_8877, 1'b0, 2, 1, 0, 32'h0, 1'b0);
    apply_stimulus("SB 0x11",  1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFF_FFAB, 32'h0000_8877, 1'b0, 3, 1, 1, 32'h88AB_6655, 1'b0);
    check("SB memory word", mem[4], 32'h88AB_6655);
    apply_stimulus("SH 0x12",  1'b1, SZ_HALF, 1'b0, 32'h12, 32'hFFFF_1234, 32'h0000_8877, 1'b0, 3, 1, 1, 32'h88AB_1234, 1'b0);
    check("SH memory word", mem[4], 32'h88AB_1234);
    apply_stimulus("SW 0x20",  1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0000_8877, 1'b0, 2, 0, 1, 32'hDEAD_BEEF, 1'b0);
    check("SW memory word", mem[8], 32'hDEAD_BEEF);
    apply_stimulus("LW 0x20",  1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0, 32'h0, 1'b0);

    apply_stimulus("LW 0x12 misaligned", 1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0, 0, 32'h0, 1'b0);
    apply_stimulus("SH 0x11 misaligned", 1'b1, SZ_HALF, 1'b0, 32'h11, 32'hFFFF_0000, 32'hDEAD_BEEF, 1'b1, 1, 0, 0, 32'h0, 1'b0);
    apply_stimulus("Size 11",            1'b0, SZ_ILL,  1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, 0, 0, 32'h0, 1'b0);
    check("error path memory word", mem[4], 32'h88AB_1234);

    apply_stimulus("LB 0x11 with Req held", 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFAB, 1'b0, 2, 1, 0, 32'h0, 1'b1);
    check("ignored SW left memory", mem[8], 32'hDEAD_BEEF);
    apply_stimulus("LHU 0x12", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'h0000_1234, 1'b0, 2, 1, 0, 32'h0, 1'b0);
    apply_stimulus("LH 0x10 back-to-back", 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'hFFFF_88AB, 1'b0, 2, 1, 0, 32'h0, 1'b0);

    @(posedge clk);
    #1;
    Req = 1'b1; We = 1'b1; Size = SZ_WORD; Unsigned = 1'b0; Addr = 32'h30; WData = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    Req = 1'b0;
    check("in WRITE DmWR", {31'd0, DmWR}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset in WRITE DmWR", {31'd0, DmWR}, 32'd0);
    check("reset in WRITE Busy", {31'd0, Busy}, 32'd0);
    check("reset in WRITE Done", {31'd0, Done}, 32'd0);
    check("reset in WRITE AddrErr", {31'd0, AddrErr}, 32'd0);
    check("reset in WRITE DmRD", {31'd0, DmRD}, 32'd0);
    check("reset in WRITE RData", RData, 32'd0);
    check("reset in WRITE DmAddr", DmAddr, 32'd0);
    check("reset in WRITE DmDataIn", DmDataIn, 32'd0);
    @(negedge clk);
    #1;
    check("reset in WRITE memory word", mem[12], 32'h1111_1111);
    rst_n = 1'b1;

    apply_stimulus("LW 0x20 after reset", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
